mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants allowed while an instruction request is pending.
REQ-002 SHALL have parameter TIMEOUT, default 15: the maximum number of cycles one access waits for completion before it is abandoned.
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction address
- ihit  out  1  one-cycle instruction completion pulse
- iload  out  32  instruction word
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dhit  out  1  one-cycle data completion pulse
- dload  out  32  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  one-cycle pulse on RAM ERROR or timeout

Function
REQ-004 SHALL implement a registered FSM with states IDLE, I_ACC and D_ACC; exactly one requester owns the RAM port in I_ACC or D_ACC.
REQ-005 In IDLE, the next state SHALL be chosen as follows:
- D_ACC if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT)
- otherwise I_ACC if iREN
- otherwise stay in IDLE
REQ-006 Grant decisions SHALL take effect on the next edge; the RAM port SHALL idle (ramREN=ramWEN=0, ramaddr=0, ramstore=0) in IDLE, so minimum latency from request to hit is 2 cycles.
REQ-007 In I_ACC, the block SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-008 In D_ACC, the block SHALL drive ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore; dREN and dWEN together SHALL be treated as a write.
REQ-009 When ramstate==ACCESS in I_ACC, ihit SHALL be 1 and iload=ramload combinationally in that cycle, and the FSM SHALL return to IDLE.
REQ-010 When ramstate==ACCESS in D_ACC, dhit SHALL be 1 in that cycle (and dload=ramload), and the FSM SHALL return to IDLE.
REQ-011 iload and dload SHALL be 0 whenever their hit is 0.
REQ-012 ihit and dhit SHALL never be 1 in the same cycle.
REQ-013 When ramstate==ERROR in I_ACC or D_ACC, err SHALL pulse for 1 cycle, no hit SHALL be asserted, and the FSM SHALL return to IDLE.
REQ-014 The wait counter SHALL clear on entry to I_ACC or D_ACC and increment each cycle without ACCESS or ERROR.
REQ-015 When the wait counter reaches TIMEOUT, err SHALL pulse, no hit SHALL be asserted, and the FSM SHALL return to IDLE.
REQ-016 If the owning request deasserts while in I_ACC or D_ACC (iREN=0, or dREN=dWEN=0), the access SHALL be aborted: the FSM returns to IDLE with no hit and no err, the RAM enables drop in that same cycle, and starve_cnt is left unchanged.
REQ-017 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each dhit cycle in which iREN=1.
REQ-018 starve_cnt SHALL clear on ihit and on any dhit cycle with iREN=0.
REQ-019 err completions SHALL leave starve_cnt unchanged.
REQ-020 Address and data inputs SHALL be sampled continuously; the requester SHALL hold them stable until its hit.

Reset
REQ-021 While RST=1 at a rising edge, the block SHALL force state=IDLE, starve_cnt=0 and wait counter=0, regardless of any in-flight access.
REQ-022 While RST=1, all outputs SHALL be 0 (ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err) from the cycle following that edge.
REQ-023 An access interrupted by reset SHALL produce no hit or err after reset deasserts.

Verification
REQ-024 Scenario: iREN=1, iaddr=0x40, ramstate=ACCESS one cycle after grant, ramload=0x00A00093 -> ihit=1 with iload=0x00A00093 at cycle 2, ramREN=1 and ramaddr=0x40 during I_ACC.
REQ-025 Scenario: iREN and dWEN rise together, daddr=0x100, dstore=0xDEADBEEF -> D_ACC first with ramWEN=1, ramstore=0xDEADBEEF, dhit; I_ACC granted next.
REQ-026 Scenario: iREN held high while dREN is re-asserted after every dhit, STARVE_LIMIT=4 -> after 4 dhits the next grant is I_ACC; ihit clears starve_cnt to 0.
REQ-027 Scenario: ramstate held BUSY in D_ACC for 15 cycles -> err pulses once, dhit stays 0, FSM in IDLE, RAM enables 0.
REQ-028 Scenario: ramstate=ERROR in I_ACC -> err=1 for 1 cycle, ihit=0; iREN still high -> regranted 2 cycles later.
REQ-029 Scenario: RST=1 asserted mid-D_ACC with ramstate BUSY -> outputs 0 from the next cycle; after RST=0 with dREN still high, a fresh grant yields a normal dhit.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter. Instruction and data masters share one RAM port.
// Data wins by default. Instruction fetch is forced through after STARVE_LIMIT
// consecutive data grants. Every access is bounded by TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;

  logic d_req;
  logic starved;
  logic owner_req;
  logic ram_done;
  logic ram_fail;

  assign d_req     = dREN | dWEN;
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign owner_req = (state == I_ACC) ? iREN : d_req;
  assign ram_done  = (ramstate == RAM_ACCESS);
  // Either the RAM reports an error or this is the last allowed wait cycle.
  assign ram_fail  = (ramstate == RAM_ERROR) || (wait_cnt == WW'(TIMEOUT - 1));

  // State, fairness counter and wait counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

  // Next-state, RAM port drive and completion outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    wait_nxt   = wait_cnt;
    ihit       = 1'b0;
    iload      = '0;
    dhit       = 1'b0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        wait_nxt = '0;
        if (d_req && !(iREN && starved)) state_nxt = D_ACC;
        else if (iREN)                   state_nxt = I_ACC;
      end

      I_ACC, D_ACC: begin
        if (!owner_req) begin
          // Requester withdrew: abandon silently, port goes idle right away.
          state_nxt = IDLE;
        end else begin
          if (state == I_ACC) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
          end else begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
          end

          if (ram_done) begin
            state_nxt = IDLE;
            if (state == I_ACC) begin
              ihit       = 1'b1;
              iload      = ramload;
              starve_nxt = '0;
            end else begin
              dhit  = 1'b1;
              dload = ramload;
              if (!iREN)        starve_nxt = '0;
              else if (!starved) starve_nxt = starve_cnt + 1'b1;
            end
          end else if (ram_fail) begin
            err       = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all outputs compared each cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: who owns the port (0 none, 1 instr, 2 data), how many cycles the
  // current access has waited, and how many data grants in a row while
  // the instruction side was waiting.
  int owner  = 0;
  int waited = 0;
  int starve = 0;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One clock: evaluate the model on current inputs, compare, advance.
  task automatic cycle(input string tag);
    int n_owner, n_wait, n_starve;
    logic x_ihit, x_dhit, x_ren, x_wen, x_err;
    logic [31:0] x_iload, x_dload, x_addr, x_store;
    logic want;
    n_owner = owner; n_wait = waited; n_starve = starve;
    x_ihit = 0; x_dhit = 0; x_ren = 0; x_wen = 0; x_err = 0;
    x_iload = 0; x_dload = 0; x_addr = 0; x_store = 0;
    #1;
    if (owner == 0) begin
      n_wait = 0;
      if ((dREN || dWEN) && !(iREN && starve == STARVE_LIMIT)) n_owner = 2;
      else if (iREN) n_owner = 1;
    end else begin
      want = (owner == 1) ? iREN : (dREN || dWEN);
      if (!want) n_owner = 0;
      else begin
        if (owner == 1) begin
          x_ren = 1; x_addr = iaddr;
        end else begin
          x_wen = dWEN; x_ren = dREN && !dWEN; x_addr = daddr; x_store = dstore;
        end
        if (ramstate == ACCESS) begin
          n_owner = 0;
          if (owner == 1) begin
            x_ihit = 1; x_iload = ramload; n_starve = 0;
          end else begin
            x_dhit = 1; x_dload = ramload;
            n_starve = !iREN ? 0 : (starve < STARVE_LIMIT ? starve + 1 : starve);
          end
        end else if (ramstate == ERROR || waited + 1 == TIMEOUT) begin
          x_err = 1; n_owner = 0;
        end else begin
          n_wait = waited + 1;
        end
      end
    end
    chk(tag, "ihit",     32'(ihit),   32'(x_ihit));
    chk(tag, "iload",    iload,       x_iload);
    chk(tag, "dhit",     32'(dhit),   32'(x_dhit));
    chk(tag, "dload",    dload,       x_dload);
    chk(tag, "ramREN",   32'(ramREN), 32'(x_ren));
    chk(tag, "ramWEN",   32'(ramWEN), 32'(x_wen));
    chk(tag, "ramaddr",  ramaddr,     x_addr);
    chk(tag, "ramstore", ramstore,    x_store);
    chk(tag, "err",      32'(err),    32'(x_err));
    chk(tag, "excl",     32'(ihit & dhit), 32'(0));
    @(posedge CLK);
    if (RST) begin
      owner = 0; waited = 0; starve = 0;
    end else begin
      owner = n_owner; waited = n_wait; starve = n_starve;
    end
    @(negedge CLK);
  endtask

  initial begin
    int nerr, ndhit;
    RST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    @(negedge CLK);

    // Reset holds everything quiet.
    cycle("reset0");
    #1; chk("reset", "ramREN", 32'(ramREN), 32'(0));
    chk("reset", "err", 32'(err), 32'(0));
    cycle("reset1");
    RST = 0;

    // Single instruction fetch, hit one cycle after the grant.
    iREN = 1; iaddr = 32'h40; ramload = 32'h00A00093;
    cycle("ifetch_idle");
    ramstate = ACCESS;
    #1; chk("ifetch", "ramaddr", ramaddr, 32'h40);
    chk("ifetch", "iload", iload, 32'h00A00093);
    chk("ifetch", "ihit", 32'(ihit), 32'(1));
    cycle("ifetch_acc");
    iREN = 0; ramstate = FREE;
    cycle("ifetch_done");

    // Simultaneous requests: data first, then instruction.
    iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; iaddr = 32'h44;
    cycle("both_idle");
    ramstate = ACCESS;
    #1; chk("both", "ramWEN", 32'(ramWEN), 32'(1));
    chk("both", "ramstore", ramstore, 32'hDEADBEEF);
    chk("both", "dhit", 32'(dhit), 32'(1));
    cycle("both_dacc");
    dWEN = 0; ramstate = FREE;
    cycle("both_idle2");
    ramstate = ACCESS;
    #1; chk("both", "ihit2", 32'(ihit), 32'(1));
    cycle("both_iacc");
    iREN = 0; ramstate = FREE;
    cycle("both_done");

    // Starvation guard: four data grants, then instruction must win.
    iREN = 1; dREN = 1; daddr = 32'h200; iaddr = 32'h80;
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      ramstate = FREE; ramload = 32'h1000 + k;
      cycle("starve_idle");
      ramstate = ACCESS;
      cycle("starve_dacc");
    end
    ramstate = FREE;
    cycle("starve_pick");
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    #1; chk("starve", "ihit", 32'(ihit), 32'(1));
    chk("starve", "dhit", 32'(dhit), 32'(0));
    cycle("starve_iacc");
    ramstate = FREE;
    cycle("starve_after");
    ramstate = ACCESS;
    #1; chk("starve", "dhit_after_clear", 32'(dhit), 32'(1));
    cycle("starve_dacc2");
    iREN = 0; dREN = 0; ramstate = FREE;
    cycle("starve_done");

    // Timeout on a data read that never completes.
    dREN = 1; daddr = 32'h300; ramstate = BUSY;
    cycle("to_idle");
    nerr = 0; ndhit = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1; nerr += int'(err); ndhit += int'(dhit);
      cycle("to_wait");
    end
    chk("timeout", "err_pulses", 32'(nerr), 32'(1));
    chk("timeout", "dhit_count", 32'(ndhit), 32'(0));
    dREN = 0;
    #1; chk("timeout", "ramREN", 32'(ramREN), 32'(0));
    cycle("to_done");

    // RAM error on instruction fetch, then regrant.
    iREN = 1; iaddr = 32'h84; ramstate = FREE;
    cycle("ierr_idle");
    ramstate = ERROR;
    #1; chk("ierr", "err", 32'(err), 32'(1));
    chk("ierr", "ihit", 32'(ihit), 32'(0));
    cycle("ierr_acc");
    ramstate = FREE;
    cycle("ierr_idle2");
    #1; chk("ierr", "regrant", 32'(ramREN), 32'(1));
    ramstate = ACCESS; ramload = 32'h13;
    cycle("ierr_retry");
    iREN = 0; ramstate = FREE;
    cycle("ierr_done");

    // Reset in the middle of a stalled data access.
    dREN = 1; daddr = 32'h400; ramstate = BUSY;
    cycle("rst_idle");
    cycle("rst_wait0");
    cycle("rst_wait1");
    RST = 1;
    cycle("rst_edge");
    #1; chk("rst", "ramREN", 32'(ramREN), 32'(0));
    chk("rst", "ramaddr", ramaddr, 32'h0);
    cycle("rst_hold");
    RST = 0; ramstate = FREE;
    cycle("rst_regrant");
    ramstate = ACCESS; ramload = 32'h12345678;
    #1; chk("rst", "dhit", 32'(dhit), 32'(1));
    chk("rst", "dload", dload, 32'h12345678);
    cycle("rst_dacc");
    dREN = 0; ramstate = FREE;
    cycle("rst_done");

    // Abort: instruction request drops mid-access.
    iREN = 1; iaddr = 32'h88; ramstate = BUSY;
    cycle("abort_idle");
    cycle("abort_wait");
    iREN = 0;
    #1; chk("abort", "ramREN", 32'(ramREN), 32'(0));
    chk("abort", "err", 32'(err), 32'(0));
    cycle("abort_drop");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      int r;
      if ($urandom_range(0, 9) == 0) iREN = ~iREN;
      if ($urandom_range(0, 6) == 0) dREN = ~dREN;
      if ($urandom_range(0, 8) == 0) dWEN = ~dWEN;
      if ($urandom_range(0, 3) == 0) iaddr = $urandom;
      if ($urandom_range(0, 3) == 0) daddr = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 19);
      ramstate = (r < 9) ? BUSY : (r < 12) ? FREE : (r < 18) ? ACCESS : ERROR;
      RST = ($urandom_range(0, 79) == 0);
      cycle("rand");
    end
    RST = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
